// File: rtl/prbs_pkg.sv
// Shared definitions for the 32-bit Fibonacci PRBS generator/checker pair.
// Tap mask, seed and checker state encoding live here so both ends agree.
package prbs_pkg;

  localparam int          LFSR_W    = 32;
  // Taps 27,23,19,18,15,11,7,4,1 as a bit mask over the 32-bit register.
  localparam logic [31:0] LFSR_TAPS = 32'h088C_8892;
  localparam logic [31:0] LFSR_SEED = 32'd11927533;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_chk_state_e;

endpackage

// File: rtl/lfsr_fb.sv
// Feedback bit of the PRBS LFSR: XOR of the register at the shared tap set.
// Used by both generator and checker so the polynomial has one definition.
module lfsr_fb
  import prbs_pkg::*;
(
  input  logic [LFSR_W-1:0] i_vec,
  output logic              o_fb
);

  assign o_fb = ^(i_vec & LFSR_TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Self-seeding PRBS checker: locks onto the generator stream, counts bit errors,
// drops lock on an error burst. Optional bit counter under PRBS_CHK_BITCNT_EN.
//
// state  | meaning
// SEARCH | filling ref_q, then counting consecutive correct predictions
// LOCKED | checking each valid bit, counting errors per observation window
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int ERR_CNT_W   = 16,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 bit_valid_i,
  input  logic                 data_bit_i,
  input  logic                 clr_err_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
`ifdef PRBS_CHK_BITCNT_EN
  output logic [31:0]          bit_cnt_o,
`endif
  output logic                 lock_lost_o
);

  localparam int                WIN_W     = $clog2(WIN_LEN);
  localparam int                WERR_W    = $clog2(LOSS_THRESH + 1);
  localparam logic [5:0]        FILL_DONE = 6'(LFSR_W);
  localparam logic [5:0]        RUN_DONE  = 6'(LFSR_W);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [WERR_W-1:0] WERR_LIM  = WERR_W'(LOSS_THRESH);

  prbs_chk_state_e r_state, w_state_nxt;

  logic [LFSR_W-1:0]    r_ref;
  logic [5:0]           r_fill, w_fill_nxt;
  logic [5:0]           r_run, w_run_nxt;
  logic [WIN_W-1:0]     r_win_cnt, w_win_cnt_nxt;
  logic [WERR_W-1:0]    r_win_err, w_win_err_nxt, w_win_err_sum;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_err, r_lock_lost;
  logic                 w_pred, w_match, w_ref_nz, w_bit_err, w_lost;

  lfsr_fb u_fb (
    .i_vec (r_ref),
    .o_fb  (w_pred)
  );

  assign w_match  = (data_bit_i == w_pred);
  // An all-zero reference predicts zero forever; never treat that as a match run.
  assign w_ref_nz = |r_ref;

  always_comb begin
    w_state_nxt   = r_state;
    w_fill_nxt    = r_fill;
    w_run_nxt     = r_run;
    w_win_cnt_nxt = r_win_cnt;
    w_win_err_nxt = r_win_err;
    w_win_err_sum = r_win_err;
    w_bit_err     = 1'b0;
    w_lost        = 1'b0;
    if (bit_valid_i) begin
      case (r_state)
        SEARCH: begin
          if (r_fill != FILL_DONE) begin
            w_fill_nxt = r_fill + 6'd1;
          end else if (r_run == RUN_DONE) begin
            w_state_nxt = LOCKED;
          end else if (w_match && w_ref_nz) begin
            w_run_nxt = r_run + 6'd1;
          end else begin
            w_run_nxt = '0;
          end
        end
        LOCKED: begin
          w_bit_err     = ~w_match;
          w_win_err_sum = r_win_err + WERR_W'(w_bit_err);
          // Threshold is tested before the window wrap so a last-bit error still counts.
          if (w_win_err_sum == WERR_LIM) begin
            w_state_nxt   = SEARCH;
            w_lost        = 1'b1;
            w_fill_nxt    = '0;
            w_run_nxt     = '0;
            w_win_cnt_nxt = '0;
            w_win_err_nxt = '0;
          end else if (r_win_cnt == WIN_LAST) begin
            w_win_cnt_nxt = '0;
            w_win_err_nxt = '0;
          end else begin
            w_win_cnt_nxt = r_win_cnt + WIN_W'(1);
            w_win_err_nxt = w_win_err_sum;
          end
        end
        default: begin
          w_state_nxt = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= SEARCH;
      r_ref       <= '0;
      r_fill      <= '0;
      r_run       <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err       <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill      <= w_fill_nxt;
      r_run       <= w_run_nxt;
      r_win_cnt   <= w_win_cnt_nxt;
      r_win_err   <= w_win_err_nxt;
      r_err       <= w_bit_err;
      r_lock_lost <= w_lost;
      if (bit_valid_i) begin
        r_ref <= {r_ref[LFSR_W-2:0], data_bit_i};
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_err_cnt <= '0;
    end else if (clr_err_i) begin
      r_err_cnt <= '0;
    end else if (w_bit_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] r_bit_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_bit_cnt <= '0;
    end else if (clr_err_i) begin
      r_bit_cnt <= '0;
    end else if (bit_valid_i && (r_state == LOCKED)) begin
      r_bit_cnt <= r_bit_cnt + 32'd1;
    end
  end

  assign bit_cnt_o = r_bit_cnt;
`endif

  assign locked_o    = (r_state == LOCKED);
  assign err_o       = r_err;
  assign err_cnt_o   = r_err_cnt;
  assign lock_lost_o = r_lock_lost;

endmodule
